// File: rtl/trig_phase_seq_pkg.sv
// Shared definitions for the MMCM phase-step sequencer: state encoding and
// default limits used by the top and its timeout counter.
package trig_phase_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam int cMAX_PHASE_DEFAULT = 1120;
  localparam int cTIMEOUT_DEFAULT   = 255;

endpackage

// File: rtl/trig_phase_seq_timeout_ctr.sv
// Counts WAIT cycles after a psen; expired_o flags the last allowed cycle
// so the sequencer can give up on a missing psdone.
module ps_timeout_ctr
  import trig_phase_seq_pkg::*;
#(
  parameter int pTIMEOUT_CYCLES = cTIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int cCW = $clog2(pTIMEOUT_CYCLES + 1);
  localparam logic [cCW-1:0] cLast = cCW'(pTIMEOUT_CYCLES - 1);

  logic [cCW-1:0] cnt_q;
  logic [cCW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != cLast)) begin
      cnt_d = cnt_q + cCW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Counter value 0 is the first WAIT cycle, so cLast marks the final one.
  assign expired_o = enable_i && (cnt_q == cLast);

endmodule

// File: rtl/trig_phase_seq.sv
// Steps an MMCM fine phase shift one increment at a time from the current
// position toward a signed target, with range, timeout, abort and lock handling.
module trig_phase_seq
  import trig_phase_seq_pkg::*;
#(
  parameter int pPHASE_WIDTH    = 16,
  parameter int pMAX_PHASE      = cMAX_PHASE_DEFAULT,
  parameter int pTIMEOUT_CYCLES = cTIMEOUT_DEFAULT
) (
  input  logic                           cwusb_clk,
  input  logic                           reset_n,
  input  logic signed [pPHASE_WIDTH-1:0] I_target,
  input  logic                           I_target_wr,
  input  logic                           I_abort,
  input  logic                           I_mmcm_locked,
  input  logic                           I_psdone,
  input  logic                           I_err_clear,
  output logic                           O_psen,
  output logic                           O_psincdec,
  output logic signed [pPHASE_WIDTH-1:0] O_current,
  output logic                           O_busy,
  output logic                           O_done,
  output logic                           O_err_range,
  output logic                           O_err_timeout
);

  localparam logic signed [pPHASE_WIDTH-1:0] cMaxPos = pPHASE_WIDTH'(pMAX_PHASE);
  localparam logic signed [pPHASE_WIDTH-1:0] cMaxNeg = -cMaxPos;

  state_e state_q, state_d;
  logic signed [pPHASE_WIDTH-1:0] target_q, target_d;
  logic signed [pPHASE_WIDTH-1:0] current_q, current_d;
  logic psen_q, psen_d;
  logic psincdec_q, psincdec_d;
  logic done_q, done_d;
  logic abortPend_q, abortPend_d;
  logic errRange_q, errRange_d;
  logic errTimeout_q, errTimeout_d;

  logic inRange;
  logic wrLive;
  logic wrValid;
  logic rangeErr;
  logic tmoExpired;
  logic signed [pPHASE_WIDTH-1:0] effTarget;
  logic signed [pPHASE_WIDTH-1:0] stepCur;

  // Abort and loss of lock both swallow a write, including its range error.
  assign inRange   = (I_target <= cMaxPos) && (I_target >= cMaxNeg);
  assign wrLive    = I_target_wr && I_mmcm_locked && !I_abort;
  assign wrValid   = wrLive && inRange;
  assign rangeErr  = wrLive && !inRange;
  assign effTarget = wrValid ? I_target : target_q;
  assign stepCur   = psincdec_q ? (current_q + pPHASE_WIDTH'(1))
                                : (current_q - pPHASE_WIDTH'(1));

  ps_timeout_ctr #(
    .pTIMEOUT_CYCLES(pTIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (cwusb_clk),
    .rst_ni   (reset_n),
    .clear_i  (state_q == ST_ISSUE),
    .enable_i (state_q == ST_WAIT),
    .expired_o(tmoExpired)
  );

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    current_d    = current_q;
    psen_d       = 1'b0;
    psincdec_d   = psincdec_q;
    done_d       = 1'b0;
    abortPend_d  = abortPend_q;
    errRange_d   = errRange_q;
    errTimeout_d = errTimeout_q;

    if (I_err_clear) begin
      errRange_d   = 1'b0;
      errTimeout_d = 1'b0;
    end
    if (rangeErr) begin
      errRange_d = 1'b1;
    end
    if (wrValid) begin
      target_d = I_target;
    end

    if (!I_mmcm_locked) begin
      state_d     = ST_IDLE;
      target_d    = '0;
      current_d   = '0;
      abortPend_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (I_abort) begin
            target_d = current_q;
          end else if (effTarget != current_q) begin
            state_d    = ST_ISSUE;
            psen_d     = 1'b1;
            psincdec_d = (effTarget > current_q);
          end else if (wrValid) begin
            done_d = 1'b1;
          end
        end
        ST_ISSUE: begin
          // psen is already out, so an abort here still waits for its psdone.
          state_d = ST_WAIT;
          if (I_abort) begin
            abortPend_d = 1'b1;
          end
        end
        ST_WAIT: begin
          if (I_psdone) begin
            current_d = stepCur;
            if (abortPend_q || I_abort) begin
              target_d    = stepCur;
              state_d     = ST_IDLE;
              abortPend_d = 1'b0;
            end else if (effTarget == stepCur) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d    = ST_ISSUE;
              psen_d     = 1'b1;
              psincdec_d = (effTarget > stepCur);
            end
          end else if (tmoExpired) begin
            errTimeout_d = 1'b1;
            target_d     = current_q;
            state_d      = ST_IDLE;
            abortPend_d  = 1'b0;
          end else if (I_abort) begin
            abortPend_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge cwusb_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      target_q     <= '0;
      current_q    <= '0;
      psen_q       <= 1'b0;
      psincdec_q   <= 1'b0;
      done_q       <= 1'b0;
      abortPend_q  <= 1'b0;
      errRange_q   <= 1'b0;
      errTimeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      current_q    <= current_d;
      psen_q       <= psen_d;
      psincdec_q   <= psincdec_d;
      done_q       <= done_d;
      abortPend_q  <= abortPend_d;
      errRange_q   <= errRange_d;
      errTimeout_q <= errTimeout_d;
    end
  end

  assign O_psen        = psen_q;
  assign O_psincdec    = psincdec_q;
  assign O_current     = current_q;
  assign O_busy        = (state_q != ST_IDLE);
  assign O_done        = done_q;
  assign O_err_range   = errRange_q;
  assign O_err_timeout = errTimeout_q;

endmodule

// File: tb/tb_trig_phase_seq.sv
// Directed bench for trig_phase_seq: an MMCM responder answers psen with
// psdone, and a scoreboard holds the expected step directions and done positions.
module tb_trig_phase_seq;

  logic               cwusb_clk = 1'b0;
  logic               reset_n = 1'b1;
  logic signed [15:0] I_target = '0;
  logic               I_target_wr = 1'b0;
  logic               I_abort = 1'b0;
  logic               I_mmcm_locked = 1'b0;
  logic               I_psdone;
  logic               I_err_clear = 1'b0;
  logic               O_psen;
  logic               O_psincdec;
  logic signed [15:0] O_current;
  logic               O_busy;
  logic               O_done;
  logic               O_err_range;
  logic               O_err_timeout;

  int checks = 0;
  int errors = 0;
  bit dirQ[$];
  int doneQ[$];
  int psenCount = 0;
  int psdoneCount = 0;
  int doneCount = 0;
  int psdoneDelay = 2;
  bit withhold = 1'b0;
  bit lastDir = 1'b0;
  int dly = 0;
  int baseP, baseD, basePd, cyc;

  trig_phase_seq dut (
    .cwusb_clk    (cwusb_clk),
    .reset_n      (reset_n),
    .I_target     (I_target),
    .I_target_wr  (I_target_wr),
    .I_abort      (I_abort),
    .I_mmcm_locked(I_mmcm_locked),
    .I_psdone     (I_psdone),
    .I_err_clear  (I_err_clear),
    .O_psen       (O_psen),
    .O_psincdec   (O_psincdec),
    .O_current    (O_current),
    .O_busy       (O_busy),
    .O_done       (O_done),
    .O_err_range  (O_err_range),
    .O_err_timeout(O_err_timeout)
  );

  initial forever #5 cwusb_clk = ~cwusb_clk;

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge cwusb_clk);
    #3;
  endtask

  task automatic applyStimulus(input int target);
    I_target    = 16'(target);
    I_target_wr = 1'b1;
    step();
    I_target_wr = 1'b0;
  endtask

  task automatic waitIdle(input string tag, input int maxCycles, output int cycles);
    cycles = 0;
    while (O_busy && cycles < maxCycles) begin
      step();
      cycles++;
    end
    checkOutput(tag, O_busy, 0);
    step();
  endtask

  task automatic waitPsdone(input int goal, input int maxCycles);
    int n = 0;
    while (psdoneCount < goal && n < maxCycles) begin
      step();
      n++;
    end
    checkOutput("psdone_wait", psdoneCount >= goal, 1);
  endtask

  // MMCM model plus scoreboard pop side; everything runs on the falling edge.
  initial begin
    I_psdone = 1'b0;
    forever begin
      @(negedge cwusb_clk);
      if (O_done === 1'b1) begin
        doneCount++;
        checkOutput("done_expected", doneQ.size() > 0, 1);
        if (doneQ.size() > 0) checkOutput("done_current", O_current, doneQ.pop_front());
      end
      if (!reset_n || !I_mmcm_locked) begin
        dly = 0;
        I_psdone = 1'b0;
      end
      if (O_psen === 1'b1) begin
        psenCount++;
        lastDir = O_psincdec;
        checkOutput("psen_expected", dirQ.size() > 0, 1);
        if (dirQ.size() > 0) checkOutput("psincdec", O_psincdec, dirQ.pop_front());
        I_psdone = 1'b0;
        if (!withhold && reset_n && I_mmcm_locked) dly = psdoneDelay;
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          I_psdone = 1'b1;
          psdoneCount++;
          checkOutput("psincdec_stable", O_psincdec, lastDir);
        end else begin
          I_psdone = 1'b0;
        end
      end else begin
        I_psdone = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1 reset_n = 1'b0;
    #1;
    checkOutput("rst_psen", O_psen, 0);
    checkOutput("rst_psincdec", O_psincdec, 0);
    checkOutput("rst_current", O_current, 0);
    checkOutput("rst_busy", O_busy, 0);
    checkOutput("rst_done", O_done, 0);
    checkOutput("rst_err_range", O_err_range, 0);
    checkOutput("rst_err_timeout", O_err_timeout, 0);
    repeat (3) step();
    reset_n = 1'b1;
    I_mmcm_locked = 1'b1;
    repeat (2) step();

    // Three increments from 0 to 3.
    psdoneDelay = 2;
    baseP = psenCount;
    baseD = doneCount;
    repeat (3) dirQ.push_back(1'b1);
    doneQ.push_back(3);
    applyStimulus(3);
    checkOutput("first_psen", O_psen, 1);
    checkOutput("first_busy", O_busy, 1);
    checkOutput("first_dir", O_psincdec, 1);
    step();
    checkOutput("psen_one_cycle", O_psen, 0);
    waitIdle("up3_idle", 100, cyc);
    checkOutput("up3_current", O_current, 3);
    checkOutput("up3_psen_count", psenCount - baseP, 3);
    checkOutput("up3_done_count", doneCount - baseD, 1);

    // Write equal to current: immediate done, no step.
    baseP = psenCount;
    baseD = doneCount;
    doneQ.push_back(3);
    applyStimulus(3);
    checkOutput("equal_done", O_done, 1);
    checkOutput("equal_psen", O_psen, 0);
    checkOutput("equal_busy", O_busy, 0);
    repeat (2) step();
    checkOutput("equal_no_psen", psenCount - baseP, 0);
    checkOutput("equal_done_count", doneCount - baseD, 1);

    // Range limits.
    psdoneDelay = 1;
    repeat (1123) dirQ.push_back(1'b0);
    doneQ.push_back(-1120);
    applyStimulus(-1120);
    waitIdle("to_min_idle", 4000, cyc);
    checkOutput("min_current", O_current, -1120);
    baseP = psenCount;
    applyStimulus(1121);
    checkOutput("over_err_range", O_err_range, 1);
    checkOutput("over_busy", O_busy, 0);
    step();
    checkOutput("over_current", O_current, -1120);
    I_err_clear = 1'b1;
    step();
    I_err_clear = 1'b0;
    checkOutput("err_range_cleared", O_err_range, 0);
    applyStimulus(-1121);
    checkOutput("under_err_range", O_err_range, 1);
    I_target = 16'sd1200;
    I_target_wr = 1'b1;
    I_err_clear = 1'b1;
    step();
    I_target_wr = 1'b0;
    I_err_clear = 1'b0;
    checkOutput("set_beats_clear", O_err_range, 1);
    I_err_clear = 1'b1;
    step();
    I_err_clear = 1'b0;
    checkOutput("err_range_cleared2", O_err_range, 0);
    checkOutput("range_no_psen", psenCount - baseP, 0);

    // Loss of lock while idle, and writes ignored while unlocked.
    I_mmcm_locked = 1'b0;
    step();
    checkOutput("unlock_current", O_current, 0);
    applyStimulus(7);
    checkOutput("unlock_wr_err", O_err_range, 0);
    checkOutput("unlock_wr_busy", O_busy, 0);
    I_mmcm_locked = 1'b1;
    repeat (2) step();
    checkOutput("relock_busy", O_busy, 0);
    checkOutput("relock_no_psen", psenCount - baseP, 0);

    // psdone withheld: timeout after the full WAIT budget.
    withhold = 1'b1;
    psdoneDelay = 2;
    baseD = doneCount;
    dirQ.push_back(1'b1);
    applyStimulus(1);
    waitIdle("timeout_idle", 400, cyc);
    checkOutput("timeout_busy_cycles", cyc, 256);
    checkOutput("timeout_flag", O_err_timeout, 1);
    checkOutput("timeout_current", O_current, 0);
    checkOutput("timeout_no_done", doneCount - baseD, 0);
    withhold = 1'b0;
    I_err_clear = 1'b1;
    step();
    I_err_clear = 1'b0;
    checkOutput("timeout_cleared", O_err_timeout, 0);
    repeat (3) step();
    checkOutput("timeout_stays_idle", O_busy, 0);

    // Retarget from 5 to 1 while the third step is outstanding.
    baseD = doneCount;
    basePd = psdoneCount;
    repeat (3) dirQ.push_back(1'b1);
    repeat (2) dirQ.push_back(1'b0);
    doneQ.push_back(1);
    applyStimulus(5);
    waitPsdone(basePd + 2, 50);
    applyStimulus(1);
    waitIdle("retarget_idle", 100, cyc);
    checkOutput("retarget_current", O_current, 1);
    checkOutput("retarget_done_count", doneCount - baseD, 1);

    // Back to 0, then abort in WAIT of the second step toward 10.
    dirQ.push_back(1'b0);
    doneQ.push_back(0);
    applyStimulus(0);
    waitIdle("home_idle", 50, cyc);
    checkOutput("home_current", O_current, 0);
    baseD = doneCount;
    basePd = psdoneCount;
    repeat (2) dirQ.push_back(1'b1);
    applyStimulus(10);
    waitPsdone(basePd + 1, 50);
    step();
    I_abort = 1'b1;
    step();
    I_abort = 1'b0;
    waitIdle("abort_idle", 50, cyc);
    checkOutput("abort_current", O_current, 2);
    checkOutput("abort_no_done", doneCount - baseD, 0);
    repeat (3) step();
    checkOutput("abort_stays_idle", O_busy, 0);

    // Abort beats a simultaneous write.
    baseP = psenCount;
    I_abort = 1'b1;
    I_target = 16'sd50;
    I_target_wr = 1'b1;
    step();
    I_abort = 1'b0;
    I_target_wr = 1'b0;
    checkOutput("abort_wr_busy", O_busy, 0);
    repeat (2) step();
    checkOutput("abort_wr_no_psen", psenCount - baseP, 0);
    checkOutput("abort_wr_current", O_current, 2);

    // Lock lost mid-stepping.
    basePd = psdoneCount;
    repeat (3) dirQ.push_back(1'b1);
    applyStimulus(10);
    waitPsdone(basePd + 2, 50);
    I_mmcm_locked = 1'b0;
    step();
    checkOutput("unlock_mid_current", O_current, 0);
    checkOutput("unlock_mid_busy", O_busy, 0);
    checkOutput("unlock_mid_psen", O_psen, 0);
    step();
    I_mmcm_locked = 1'b1;
    repeat (3) step();
    checkOutput("relock_mid_busy", O_busy, 0);
    checkOutput("relock_mid_current", O_current, 0);

    // Reset pulse mid-WAIT.
    dirQ.push_back(1'b1);
    applyStimulus(5);
    step();
    checkOutput("pre_reset_busy", O_busy, 1);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_psen", O_psen, 0);
    checkOutput("midrst_psincdec", O_psincdec, 0);
    checkOutput("midrst_current", O_current, 0);
    checkOutput("midrst_busy", O_busy, 0);
    checkOutput("midrst_done", O_done, 0);
    checkOutput("midrst_err_timeout", O_err_timeout, 0);
    repeat (3) step();
    reset_n = 1'b1;
    repeat (3) step();
    checkOutput("postrst_busy", O_busy, 0);
    checkOutput("postrst_current", O_current, 0);
    checkOutput("postrst_err_range", O_err_range, 0);
    checkOutput("postrst_err_timeout", O_err_timeout, 0);

    checkOutput("dirq_drained", dirQ.size(), 0);
    checkOutput("doneq_drained", doneQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
